// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RISC-V core.
// This file holds the fetch-stage constants, the fetch FSM encoding and the alignment helper.
package cpu_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [1:0]  IALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr[1:0] & IALIGN_MASK);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch responder: PC in, one instruction word out with a one-cycle iready pulse.
// Contains a one-entry last-fetch buffer and a bus timeout. Faults return a NOP with an error pulse.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP     = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] PCaddr,
    output logic        iready,
    output logic [31:0] instr,
    output logic        ifetch_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W:0] TO_LIMIT = TIMEOUT[TO_W:0];

    fetch_state_t    state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic            err_q, err_d;
    logic            iready_q;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            buf_v_q;
    logic [31:0]     buf_addr_q, buf_data_q;
    logic            buf_we;
    logic            expire;

    // Expiry means this REQ cycle would be the TIMEOUT-th one without an ack.
    assign expire = (TIMEOUT != 0) && (({1'b0, cnt_q} + (TO_W + 1)'(1)) == TO_LIMIT);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        buf_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_misaligned(PCaddr)) begin
                    instr_d = NOP;
                    err_d   = 1'b1;
                    state_d = VALID;
                end else if (buf_v_q && (PCaddr == buf_addr_q)) begin
                    instr_d = buf_data_q;
                    state_d = VALID;
                end else begin
                    addr_d  = PCaddr & ~{30'b0, IALIGN_MASK};
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack in the expiry cycle still delivers its data.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = VALID;
                    if (mem_err) begin
                        instr_d = NOP;
                        err_d   = 1'b1;
                    end else begin
                        instr_d = mem_rdata;
                        buf_we  = 1'b1;
                    end
                end else if (expire) begin
                    req_d   = 1'b0;
                    instr_d = NOP;
                    err_d   = 1'b1;
                    state_d = VALID;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            VALID: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            instr_q  <= NOP;
            err_q    <= 1'b0;
            iready_q <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            buf_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            iready_q <= (state_d == VALID);
            req_q    <= req_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            if (buf_we) begin
                buf_v_q <= 1'b1;
            end
        end
    end

    // NOTE: buffer payload is not reset; buf_v_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_addr_q <= addr_q;
            buf_data_q <= mem_rdata;
        end
    end

    assign iready     = iready_q;
    assign instr      = instr_q;
    assign ifetch_err = err_q;
    assign mem_req    = req_q;
    assign mem_addr   = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch with a transaction-level model of the fetch rules.
// The bench acts as the memory responder and the checker of latency, bus activity and returned words.
module tb_instr_fetch;

    localparam int unsigned TO      = 4;
    localparam logic [31:0] NOP_EXP = 32'h0000_0013;

    logic        clk;
    logic        RST;
    logic [31:0] PCaddr;
    logic        iready;
    logic [31:0] instr;
    logic        ifetch_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: one-entry buffer and last delivered word.
    logic        m_buf_v;
    logic [31:0] m_buf_addr;
    logic [31:0] m_buf_data;
    logic [31:0] m_last;

    instr_fetch #(.TIMEOUT(TO), .NOP(NOP_EXP)) dut (
        .clk        (clk),
        .RST        (RST),
        .PCaddr     (PCaddr),
        .iready     (iready),
        .instr      (instr),
        .ifetch_err (ifetch_err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf_v    = 1'b0;
        m_buf_addr = '0;
        m_buf_data = '0;
        m_last     = NOP_EXP;
    endtask

    // One fetch. Called at a negedge: normally in the VALID cycle of the previous fetch,
    // or (after_rst) at the negedge where reset was released, i.e. inside the IDLE cycle.
    task automatic fetch(input logic [31:0] pc, input int delay, input logic berr,
                         input logic [31:0] rdata, input bit after_rst);
        int          exp_k, exp_req, got_k, req_n, k;
        logic [31:0] exp_instr;
        logic        exp_err;
        bit          done;

        if (pc[1:0] != 2'b00) begin
            exp_req = 0; exp_k = 1; exp_instr = NOP_EXP; exp_err = 1'b1;
        end else if (m_buf_v && pc == m_buf_addr) begin
            exp_req = 0; exp_k = 1; exp_instr = m_buf_data; exp_err = 1'b0;
        end else if (delay >= int'(TO)) begin
            exp_req = TO; exp_k = TO + 1; exp_instr = NOP_EXP; exp_err = 1'b1;
        end else begin
            exp_req = delay + 1; exp_k = delay + 2;
            exp_instr = berr ? NOP_EXP : rdata;
            exp_err   = berr;
        end

        PCaddr    = pc;
        mem_ack   = after_rst ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        mem_err   = 1'($urandom_range(0, 1));

        got_k = -1;
        req_n = 0;
        done  = 1'b0;
        k     = after_rst ? 0 : -1;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
            if (k == 0) begin
                check("idle_req", mem_req, 1'b0);
                check("idle_rdy", iready, 1'b0);
            end
            if (iready) begin
                got_k = k;
                done  = 1'b1;
                check("instr", instr, exp_instr);
                check("err", ifetch_err, exp_err);
            end else begin
                check("hold", instr, m_last);
            end
            if (mem_req) begin
                req_n++;
                check("addr", mem_addr, pc);
                mem_ack   = (req_n - 1 == delay);
                mem_rdata = (req_n - 1 == delay) ? rdata : $urandom;
                mem_err   = (req_n - 1 == delay) ? berr : 1'b0;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                mem_err   = 1'($urandom_range(0, 1));
            end
        end
        check("latency", got_k, exp_k);
        check("nreq", req_n, exp_req);

        m_last = exp_instr;
        if (exp_req != 0 && delay < int'(TO) && !berr) begin
            m_buf_v    = 1'b1;
            m_buf_addr = pc;
            m_buf_data = rdata;
        end
    endtask

    initial begin
        RST       = 1'b1;
        PCaddr    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_err   = 1'b0;
        model_reset();

        #12;
        check("rst_rdy", iready, 1'b0);
        check("rst_err", ifetch_err, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_instr", instr, NOP_EXP);

        // Zero-wait miss right after reset.
        @(negedge clk);
        RST = 1'b0;
        fetch(32'h0, 0, 1'b0, 32'h0050_0093, 1'b1);

        // Wait states, buffer fill and hit, misaligned PC.
        fetch(32'h4, 3, 1'b0, 32'h0020_8133, 1'b0);
        fetch(32'h8, 1, 1'b0, 32'h0031_0213, 1'b0);
        fetch(32'h8, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h6, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Bus error leaves the buffer alone; the refetch must go to the bus.
        fetch(32'hC, 0, 1'b1, 32'h1111_1111, 1'b0);
        fetch(32'hC, 0, 1'b0, 32'h0041_8293, 1'b0);

        // Timeout, then ack coinciding with expiry.
        fetch(32'h10, 6, 1'b0, 32'h2222_2222, 1'b0);
        fetch(32'h14, TO - 1, 1'b0, 32'h0052_8313, 1'b0);

        // Reset in the middle of a waited request.
        PCaddr  = 32'h100;
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_req_pre", mem_req, 1'b1);
        @(negedge clk);
        #2 RST = 1'b1;
        #1;
        check("mid_req_async", mem_req, 1'b0);
        check("mid_rdy", iready, 1'b0);
        @(negedge clk);
        check("mid_rdy_hold", iready, 1'b0);
        check("mid_instr", instr, NOP_EXP);
        RST = 1'b0;
        model_reset();
        fetch(32'h100, 1, 1'b0, 32'h0063_0393, 1'b1);

        // Randomized traffic over a small address pool so buffer hits recur.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] pc;
            pc = 32'h40 + {27'b0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) == 0) pc = pc | 32'($urandom_range(1, 3));
            fetch(pc, $urandom_range(0, 6), ($urandom_range(0, 7) == 0), $urandom, 1'b0);
        end

        @(negedge clk);
        check("final_rdy", iready, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
